multicycle_ctrl_fsm: RTL and testbench

Main control unit for the multi-cycle RV32I datapath. It decodes the registered instruction and steps a Moore state machine that drives the datapath enables and mux selects: PC write, IR write, register write, memory write, ALU source selects, result select and alu_ctrl. It sits directly upstream of data_path and replaces the hand-driven control stimulus with per-instruction cycle sequencing. Supported subset: lw, sw, R-type ALU, I-type ALU, beq, jal.

---
 rtl/mc_ctrl_pkg.sv | 47 ++++
 rtl/multicycle_ctrl_fsm_alu_decoder.sv | 37 +++
 rtl/multicycle_ctrl_fsm.sv | 156 +++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite,
    StExecuteR, StExecuteI, StAluWb, StBeq, StJal
  } state_e;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpRType = 7'b0110011;
  localparam logic [6:0] OpIType = 7'b0010011;
  localparam logic [6:0] OpBeq   = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  localparam int unsigned AluAdd  = 0;
  localparam int unsigned AluSub  = 1;
  localparam int unsigned AluAnd  = 2;
  localparam int unsigned AluOr   = 3;
  localparam int unsigned AluXor  = 4;
  localparam int unsigned AluSlt  = 5;
  localparam int unsigned AluSll  = 6;
  localparam int unsigned AluSrl  = 7;
  localparam int unsigned AluSra  = 8;
  localparam int unsigned AluSltu = 9;

  localparam logic       AdrPc     = 1'b0;
  localparam logic       AdrAlu    = 1'b1;
  localparam logic [1:0] ResAluOut = 2'b00;
  localparam logic [1:0] ResData   = 2'b01;
  localparam logic [1:0] ResAluRes = 2'b10;
  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;
  localparam logic [1:0] SrcBRs2   = 2'b00;
  localparam logic [1:0] SrcBImm   = 2'b01;
  localparam logic [1:0] SrcBFour  = 2'b10;
  localparam logic [1:0] ImmI      = 2'b00;
  localparam logic [1:0] ImmS      = 2'b01;
  localparam logic [1:0] ImmB      = 2'b10;
  localparam logic [1:0] ImmJ      = 2'b11;

endpackage

// File: rtl/multicycle_ctrl_fsm_alu_decoder.sv
// Combinational ALU operation decode from alu_op and instruction fields.
module alu_decoder
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 5
) (
  input  logic [1:0]            i_alu_op,
  input  logic [2:0]            i_funct3,
  input  logic                  i_funct7b5,
  input  logic                  i_op5,
  output logic [ALU_CTRL_W-1:0] o_alu_ctrl
);

  always_comb begin
    o_alu_ctrl = ALU_CTRL_W'(AluAdd);
    case (i_alu_op)
      AluOpSub: o_alu_ctrl = ALU_CTRL_W'(AluSub);
      AluOpFunct: begin
        unique case (i_funct3)
          // op5 separates R-type from I-type, so addi never becomes SUB
          3'b000:  o_alu_ctrl = (i_op5 && i_funct7b5) ? ALU_CTRL_W'(AluSub)
                                                      : ALU_CTRL_W'(AluAdd);
          3'b001:  o_alu_ctrl = ALU_CTRL_W'(AluSll);
          3'b010:  o_alu_ctrl = ALU_CTRL_W'(AluSlt);
          3'b011:  o_alu_ctrl = ALU_CTRL_W'(AluSltu);
          3'b100:  o_alu_ctrl = ALU_CTRL_W'(AluXor);
          3'b101:  o_alu_ctrl = i_funct7b5 ? ALU_CTRL_W'(AluSra) : ALU_CTRL_W'(AluSrl);
          3'b110:  o_alu_ctrl = ALU_CTRL_W'(AluOr);
          3'b111:  o_alu_ctrl = ALU_CTRL_W'(AluAnd);
          default: o_alu_ctrl = ALU_CTRL_W'(AluAdd);
        endcase
      end
      default: o_alu_ctrl = ALU_CTRL_W'(AluAdd);
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Moore control FSM sequencing the multi-cycle RV32I datapath.
module multicycle_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [6:0]            i_opcode,
  input  logic [2:0]            i_funct3,
  input  logic                  i_funct7b5,
  input  logic                  i_zero,
  output logic                  o_pc_write,
  output logic                  o_adr_src,
  output logic                  o_ir_write,
  output logic                  o_mem_write,
  output logic                  o_reg_write,
  output logic [1:0]            o_result_src,
  output logic [1:0]            o_alu_src_a,
  output logic [1:0]            o_alu_src_b,
  output logic [1:0]            o_imm_src,
  output logic [ALU_CTRL_W-1:0] o_alu_ctrl,
  output logic                  o_instr_done,
  output logic                  o_illegal
);

  state_e     r_state, w_state_d, w_state;
  logic [1:0] w_alu_op;
  logic       w_pc_update, w_branch, w_ir_write, w_mem_write, w_reg_write;
  logic       w_done, w_illegal;

  always_ff @(posedge i_clk) begin
    r_state <= w_state_d;
  end

  // Under reset the outputs present FETCH values regardless of the stale state.
  assign w_state = i_reset_n ? r_state : StFetch;

  always_comb begin
    w_state_d    = StFetch;
    w_alu_op     = AluOpAdd;
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_done       = 1'b0;
    w_illegal    = 1'b0;
    o_adr_src    = AdrPc;
    o_result_src = ResAluOut;
    o_alu_src_a  = SrcAPc;
    o_alu_src_b  = SrcBRs2;
    unique case (w_state)
      StFetch: begin
        w_ir_write   = 1'b1;
        w_pc_update  = 1'b1;
        o_alu_src_b  = SrcBFour;
        o_result_src = ResAluRes;
        w_state_d    = StDecode;
      end
      StDecode: begin
        o_alu_src_a = SrcAOldPc;
        o_alu_src_b = SrcBImm;
        case (i_opcode)
          OpLoad, OpStore: w_state_d = StMemAdr;
          OpRType:         w_state_d = StExecuteR;
          OpIType:         w_state_d = StExecuteI;
          OpBeq:           w_state_d = StBeq;
          OpJal:           w_state_d = StJal;
          default: begin
            w_state_d = StFetch;
            w_illegal = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        o_alu_src_a = SrcARs1;
        o_alu_src_b = SrcBImm;
        w_state_d   = (i_opcode == OpLoad) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        o_adr_src = AdrAlu;
        w_state_d = StMemWb;
      end
      StMemWb: begin
        o_result_src = ResData;
        w_reg_write  = 1'b1;
        w_done       = 1'b1;
      end
      StMemWrite: begin
        o_adr_src   = AdrAlu;
        w_mem_write = 1'b1;
        w_done      = 1'b1;
      end
      StExecuteR: begin
        o_alu_src_a = SrcARs1;
        w_alu_op    = AluOpFunct;
        w_state_d   = StAluWb;
      end
      StExecuteI: begin
        o_alu_src_a = SrcARs1;
        o_alu_src_b = SrcBImm;
        w_alu_op    = AluOpFunct;
        w_state_d   = StAluWb;
      end
      StAluWb: begin
        w_reg_write = 1'b1;
        w_done      = 1'b1;
      end
      StBeq: begin
        o_alu_src_a = SrcARs1;
        w_alu_op    = AluOpSub;
        w_branch    = 1'b1;
        w_done      = 1'b1;
      end
      StJal: begin
        o_alu_src_a = SrcAOldPc;
        o_alu_src_b = SrcBFour;
        w_pc_update = 1'b1;
        w_state_d   = StAluWb;
      end
      default: w_state_d = StFetch;
    endcase
    if (!i_reset_n) begin
      w_state_d = StFetch;
    end
  end

  assign o_pc_write   = i_reset_n & (w_pc_update | (w_branch & i_zero));
  assign o_ir_write   = i_reset_n & w_ir_write;
  assign o_mem_write  = i_reset_n & w_mem_write;
  assign o_reg_write  = i_reset_n & w_reg_write;
  assign o_instr_done = i_reset_n & w_done;
  assign o_illegal    = i_reset_n & w_illegal;

  always_comb begin
    o_imm_src = ImmI;
    case (i_opcode)
      OpStore: o_imm_src = ImmS;
      OpBeq:   o_imm_src = ImmB;
      OpJal:   o_imm_src = ImmJ;
      default: o_imm_src = ImmI;
    endcase
  end

  alu_decoder #(
    .ALU_CTRL_W(ALU_CTRL_W)
  ) u_alu_decoder (
    .i_alu_op   (w_alu_op),
    .i_funct3   (i_funct3),
    .i_funct7b5 (i_funct7b5),
    .i_op5      (i_opcode[5]),
    .o_alu_ctrl (o_alu_ctrl)
  );

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench: driver queues per-cycle expected outputs, monitor checks them.
module tb_multicycle_ctrl_fsm;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       irw;
    logic       mw;
    logic       rw;
    logic [1:0] rs;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] imm;
    logic [4:0] alu;
    logic       done;
    logic       ill;
  } exp_t;

  localparam logic [4:0] ADD = 5'd0;
  localparam logic [4:0] SUB = 5'd1;
  localparam logic [4:0] SRA = 5'd8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write, adr_src, ir_write, mem_write, reg_write, instr_done, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [4:0] alu_ctrl;

  int    errors = 0;
  int    checks = 0;
  int    cnt    = 0;
  exp_t  q[$];
  string nq[$];
  int    cq[$];

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.ALU_CTRL_W(5)) dut (
    .i_clk        (clk),
    .i_reset_n    (reset_n),
    .i_opcode     (opcode),
    .i_funct3     (funct3),
    .i_funct7b5   (funct7b5),
    .i_zero       (zero),
    .o_pc_write   (pc_write),
    .o_adr_src    (adr_src),
    .o_ir_write   (ir_write),
    .o_mem_write  (mem_write),
    .o_reg_write  (reg_write),
    .o_result_src (result_src),
    .o_alu_src_a  (alu_src_a),
    .o_alu_src_b  (alu_src_b),
    .o_imm_src    (imm_src),
    .o_alu_ctrl   (alu_ctrl),
    .o_instr_done (instr_done),
    .o_illegal    (illegal)
  );

  function automatic exp_t row(logic pcw, logic adr, logic irw, logic mw, logic rw,
                               logic [1:0] rs, logic [1:0] a, logic [1:0] b,
                               logic [1:0] imm, logic [4:0] alu, logic done, logic ill);
    row = '{pcw, adr, irw, mw, rw, rs, a, b, imm, alu, done, ill};
  endfunction

  function automatic exp_t r_reset(logic [1:0] imm);
    return row(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, imm, ADD, 0, 0);
  endfunction
  function automatic exp_t r_fetch(logic [1:0] imm);
    return row(1, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, imm, ADD, 0, 0);
  endfunction
  function automatic exp_t r_decode(logic [1:0] imm, logic ill);
    return row(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, ADD, 0, ill);
  endfunction
  function automatic exp_t r_aluwb(logic [1:0] imm);
    return row(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, ADD, 1, 0);
  endfunction

  // Monitor: compares every queued cycle and the cycle count at each instr_done.
  always @(negedge clk) begin
    exp_t  act;
    exp_t  e;
    string nm;
    int    want;
    act = '{pc_write, adr_src, ir_write, mem_write, reg_write, result_src, alu_src_a,
            alu_src_b, imm_src, alu_ctrl, instr_done, illegal};
    if (q.size() > 0) begin
      e  = q.pop_front();
      nm = nq.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %b want %b (pcw adr irw mw rw rs a b imm alu done ill)",
                 nm, act, e);
      end
    end
    if (ir_write === 1'b1) cnt = 1;
    else cnt++;
    if (instr_done === 1'b1) begin
      checks++;
      if (cq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got instr_done=1 want no completion");
      end else begin
        want = cq.pop_front();
        if (cnt != want) begin
          errors++;
          $display("FAIL cycles: got %0d want %0d", cnt, want);
        end
      end
    end
  end

  task automatic cyc(input exp_t e, input string nm);
    q.push_back(e);
    nq.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic z);
    opcode   = op;
    funct3   = f3;
    funct7b5 = f7;
    zero     = z;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    set_in(7'b0010011, 3'b000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cyc(r_reset(2'b00), "reset");
    reset_n = 1'b1;

    // addi
    cq.push_back(4);
    cyc(r_fetch(2'b00), "addi_fetch");
    cyc(r_decode(2'b00, 0), "addi_decode");
    cyc(row(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, ADD, 0, 0), "addi_exec");
    cyc(r_aluwb(2'b00), "addi_wb");

    // lw
    set_in(7'b0000011, 3'b010, 1'b0, 1'b0);
    cq.push_back(5);
    cyc(r_fetch(2'b00), "lw_fetch");
    cyc(r_decode(2'b00, 0), "lw_decode");
    cyc(row(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, ADD, 0, 0), "lw_memadr");
    cyc(row(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, ADD, 0, 0), "lw_memread");
    cyc(row(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, ADD, 1, 0), "lw_memwb");

    // sw
    set_in(7'b0100011, 3'b010, 1'b0, 1'b0);
    cq.push_back(4);
    cyc(r_fetch(2'b01), "sw_fetch");
    cyc(r_decode(2'b01, 0), "sw_decode");
    cyc(row(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, ADD, 0, 0), "sw_memadr");
    cyc(row(0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, ADD, 1, 0), "sw_memwrite");

    // beq taken, then not taken
    for (int k = 0; k < 2; k++) begin
      logic z;
      z = (k == 0);
      set_in(7'b1100011, 3'b000, 1'b0, z);
      cq.push_back(3);
      cyc(r_fetch(2'b10), "beq_fetch");
      cyc(r_decode(2'b10, 0), "beq_decode");
      cyc(row(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, SUB, 1, 0), "beq_exec");
    end

    // R-type sub, R-type sra
    set_in(7'b0110011, 3'b000, 1'b1, 1'b0);
    cq.push_back(4);
    cyc(r_fetch(2'b00), "sub_fetch");
    cyc(r_decode(2'b00, 0), "sub_decode");
    cyc(row(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, SUB, 0, 0), "sub_exec");
    cyc(r_aluwb(2'b00), "sub_wb");

    set_in(7'b0110011, 3'b101, 1'b1, 1'b0);
    cq.push_back(4);
    cyc(r_fetch(2'b00), "sra_fetch");
    cyc(r_decode(2'b00, 0), "sra_decode");
    cyc(row(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, SRA, 0, 0), "sra_exec");
    cyc(r_aluwb(2'b00), "sra_wb");

    // addi with funct7b5 set still adds
    set_in(7'b0010011, 3'b000, 1'b1, 1'b0);
    cq.push_back(4);
    cyc(r_fetch(2'b00), "addi7_fetch");
    cyc(r_decode(2'b00, 0), "addi7_decode");
    cyc(row(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, ADD, 0, 0), "addi7_exec");
    cyc(r_aluwb(2'b00), "addi7_wb");

    // jal
    set_in(7'b1101111, 3'b000, 1'b0, 1'b0);
    cq.push_back(4);
    cyc(r_fetch(2'b11), "jal_fetch");
    cyc(r_decode(2'b11, 0), "jal_decode");
    cyc(row(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, ADD, 0, 0), "jal_exec");
    cyc(r_aluwb(2'b11), "jal_wb");

    // illegal opcode returns straight to FETCH
    set_in(7'b1111111, 3'b000, 1'b0, 1'b0);
    cyc(r_fetch(2'b00), "ill_fetch");
    cyc(r_decode(2'b00, 1), "ill_decode");
    cyc(r_fetch(2'b00), "ill_refetch");

    // sw aborted by reset in MEMADR
    set_in(7'b0100011, 3'b000, 1'b0, 1'b0);
    cyc(r_decode(2'b01, 0), "swr_decode");
    reset_n = 1'b0;
    cyc(r_reset(2'b01), "swr_reset");
    reset_n = 1'b1;
    cyc(r_fetch(2'b01), "swr_fetch");
    cyc(r_decode(2'b01, 0), "swr_decode2");

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0 || cq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending want 0/0", q.size(), cq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
